// File: rtl/aes_mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine, ColsPerCycle columns per clock.
// Holds the cipher-direction type, the single-column mixer and the sequential top.

package aes_pkg;
    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;
endpackage

// One AES column: element index = row. Forward MixColumns, or the inverse built as
// a pre-multiply by {04,00,05,00} followed by the forward matrix.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  ciph_op_e         op_i,
    input  logic [3:0][7:0]  data_i,
    output logic [3:0][7:0]  data_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [3:0][7:0] a;
    logic [7:0]      u;
    logic [7:0]      v;

    // Optional inverse pre-multiply, then the forward matrix
    always_comb begin
        a = data_i;
        u = xtime(xtime(data_i[0] ^ data_i[2]));
        v = xtime(xtime(data_i[1] ^ data_i[3]));
        if (op_i == CIPH_INV) begin
            a[0] = data_i[0] ^ u;
            a[1] = data_i[1] ^ v;
            a[2] = data_i[2] ^ u;
            a[3] = data_i[3] ^ v;
        end
        for (int r = 0; r < 4; r++) begin
            // 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
            data_o[r] = xtime(a[r] ^ a[(r + 1) % 4]) ^ a[(r + 1) % 4]
                      ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
    end

endmodule

// Sequential MixColumns over a full 4x4 state, indexed [row][col].
module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned ColsPerCycle = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  ciph_op_e              op_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0][3:0][7:0]  data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0][3:0][7:0]  data_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]           state, state_next;
    logic [1:0]           col_cnt, col_cnt_next;
    logic [2:0]           cnt_sum;
    logic [3:0][3:0][7:0] data_reg, data_reg_next;
    logic [3:0][3:0][7:0] result, result_next;
    ciph_op_e             op_reg, op_reg_next;
    logic                 err_reg, err_reg_next;
    logic                 op_ok;

    logic [1:0]      col_idx [ColsPerCycle];
    logic [3:0][7:0] mix_in  [ColsPerCycle];
    logic [3:0][7:0] mix_out [ColsPerCycle];

    // Extra bit on the counter sum flags the wrap past the last column
    assign cnt_sum = {1'b0, col_cnt} + 3'(ColsPerCycle);
    assign op_ok   = (op_reg == CIPH_FWD) || (op_reg == CIPH_INV);

    // Gather the columns handled this cycle from the captured state
    always_comb begin
        for (int k = 0; k < ColsPerCycle; k++) begin
            col_idx[k] = col_cnt + 2'(k);
            for (int r = 0; r < 4; r++) begin
                mix_in[k][r] = data_reg[r][col_idx[k]];
            end
        end
    end

    for (genvar k = 0; k < ColsPerCycle; k++) begin : g_mix
        aes_mix_single_column u_mix (
            .op_i   (op_reg),
            .data_i (mix_in[k]),
            .data_o (mix_out[k])
        );
    end

    // Next-state: handshake capture, column stepping, output handshake, clear abort
    always_comb begin
        state_next    = state;
        col_cnt_next  = col_cnt;
        data_reg_next = data_reg;
        op_reg_next   = op_reg;
        result_next   = result;
        err_reg_next  = err_reg;
        if (clear_i) begin
            state_next   = StIdle;
            col_cnt_next = 2'd0;
            result_next  = '0;
            err_reg_next = 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid_i) begin
                        data_reg_next = data_i;
                        op_reg_next   = op_i;
                        col_cnt_next  = 2'd0;
                        result_next   = '0;
                        err_reg_next  = (op_i != CIPH_FWD) && (op_i != CIPH_INV);
                        state_next    = StBusy;
                    end
                end
                StBusy: begin
                    // An illegal op leaves the result at zero but keeps normal timing
                    if (op_ok) begin
                        for (int k = 0; k < ColsPerCycle; k++) begin
                            for (int r = 0; r < 4; r++) begin
                                result_next[r][col_idx[k]] = mix_out[k][r];
                            end
                        end
                    end
                    col_cnt_next = cnt_sum[1:0];
                    if (cnt_sum[2]) begin
                        state_next = StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_next = StIdle;
                    end
                end
                default: state_next = StIdle;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= StIdle;
            col_cnt  <= 2'd0;
            data_reg <= '0;
            op_reg   <= ciph_op_e'(2'b00);
            result   <= '0;
            err_reg  <= 1'b0;
        end else begin
            state    <= state_next;
            col_cnt  <= col_cnt_next;
            data_reg <= data_reg_next;
            op_reg   <= op_reg_next;
            result   <= result_next;
            err_reg  <= err_reg_next;
        end
    end

    assign in_ready_o  = (state == StIdle);
    assign out_valid_o = (state == StDone);
    assign busy_o      = (state != StIdle);
    assign data_o      = out_valid_o ? result : '0;
    assign err_o       = out_valid_o & err_reg;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: three instances (1, 2 and 4 columns per cycle) share
// stimulus and are checked against a matrix-multiply GF(2^8) reference model.
module tb_aes_mix_columns_seq;
    import aes_pkg::*;

    typedef logic [3:0][3:0][7:0] state_t;

    logic     clk = 1'b0;
    logic     rst_ni;
    logic     clear_i;
    ciph_op_e op_i;
    logic     in_valid_i;
    logic     out_ready_i;
    state_t   data_i;

    logic   in_ready  [3];
    logic   out_valid [3];
    logic   busy      [3];
    logic   err       [3];
    state_t dout      [3];

    int lat_exp [3] = '{4, 2, 1};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_mix_columns_seq #(.ColsPerCycle(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .op_i(op_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready[0]), .data_i(data_i),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready_i), .data_o(dout[0]),
        .busy_o(busy[0]), .err_o(err[0])
    );
    aes_mix_columns_seq #(.ColsPerCycle(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .op_i(op_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready[1]), .data_i(data_i),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready_i), .data_o(dout[1]),
        .busy_o(busy[1]), .err_o(err[1])
    );
    aes_mix_columns_seq #(.ColsPerCycle(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .op_i(op_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready[2]), .data_i(data_i),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready_i), .data_o(dout[2]),
        .busy_o(busy[2]), .err_o(err[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // out[r][c] = XOR over k of M[r][k] * in[k][c], M circulant with first row coef
    function automatic state_t ref_mix(input state_t s, input logic [1:0] op);
        logic [7:0] coef [4];
        state_t     o = '0;
        if (op == 2'b01) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        else if (op == 2'b10) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else return '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    o[r][c] = o[r][c] ^ gf_mul(coef[(k - r + 4) % 4], s[k][c]);
        return o;
    endfunction

    // Each argument is one column written {row0, row1, row2, row3}
    function automatic state_t make_state(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] cols [4];
        state_t      s;
        cols = '{c0, c1, c2, c3};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = cols[c][31 - 8 * r -: 8];
        return s;
    endfunction

    function automatic state_t rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (in_ready[0] && in_ready[1] && in_ready[2]) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: in_ready got %b%b%b required 111 within 50 cycles",
                 in_ready[0], in_ready[1], in_ready[2]);
    endtask

    // One transaction with out_ready high; checks latency, data, err and zero-when-idle
    task automatic run_txn(input state_t s, input ciph_op_e op, input state_t exp,
                           input logic exp_err, input string name);
        logic seen [3] = '{1'b0, 1'b0, 1'b0};
        wait_idle();
        data_i      = s;
        op_i        = op;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        data_i     = rand_state();
        op_i       = ciph_op_e'(2'($urandom_range(0, 3)));
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            for (int j = 0; j < 3; j++) begin
                if (out_valid[j] && !seen[j]) begin
                    seen[j] = 1'b1;
                    checks += 3;
                    if (cyc !== lat_exp[j]) begin
                        errors++;
                        $display("FAIL %s inst%0d latency got %0d required %0d",
                                 name, j, cyc, lat_exp[j]);
                    end
                    if (dout[j] !== exp) begin
                        errors++;
                        $display("FAIL %s inst%0d data got %h required %h",
                                 name, j, dout[j], exp);
                    end
                    if (err[j] !== exp_err) begin
                        errors++;
                        $display("FAIL %s inst%0d err got %b required %b",
                                 name, j, err[j], exp_err);
                    end
                end else if (out_valid[j]) begin
                    checks++;
                    errors++;
                    $display("FAIL %s inst%0d out_valid got 1 required 0 after accept",
                             name, j);
                end else begin
                    checks++;
                    if (dout[j] !== '0) begin
                        errors++;
                        $display("FAIL %s inst%0d idle data got %h required 0",
                                 name, j, dout[j]);
                    end
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (!seen[j]) begin
                errors++;
                $display("FAIL %s inst%0d out_valid got never required once", name, j);
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (out_valid[j] !== 1'b0 || busy[j] !== 1'b0 || err[j] !== 1'b0 ||
                dout[j] !== '0) begin
                errors++;
                $display("FAIL %s inst%0d outputs got v%b b%b e%b d%h required all 0",
                         name, j, out_valid[j], busy[j], err[j], dout[j]);
            end
        end
    endtask

    task automatic check_idle(input string name);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (in_ready[j] !== 1'b1 || busy[j] !== 1'b0 || out_valid[j] !== 1'b0) begin
                errors++;
                $display("FAIL %s inst%0d got rdy%b busy%b v%b required rdy1 busy0 v0",
                         name, j, in_ready[j], busy[j], out_valid[j]);
            end
        end
    endtask

    task automatic check_no_output(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (out_valid[j] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s inst%0d out_valid got 1 required 0", name, j);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        check_zero_outputs("reset_hold");
        #10;
        rst_ni = 1'b1;
        step();
        check_idle("reset_release");
    endtask

    task automatic test_vectors();
        state_t a = make_state(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
        state_t b = make_state(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
        state_t m = make_state(32'h01010101, 32'hc6c6c6c6, 32'hdb135345, 32'hf20a225c);
        state_t n = make_state(32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc, 32'h9fdc589d);
        run_txn(a, CIPH_FWD, b, 1'b0, "fwd_known");
        run_txn(b, CIPH_INV, a, 1'b0, "inv_known");
        run_txn(m, CIPH_FWD, n, 1'b0, "fwd_mixed");
        run_txn(n, CIPH_INV, m, 1'b0, "inv_mixed");
        run_txn(a, ciph_op_e'(2'b11), '0, 1'b1, "op_invalid_11");
        run_txn(b, ciph_op_e'(2'b00), '0, 1'b1, "op_invalid_00");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            state_t     s  = rand_state();
            logic [1:0] op = 2'($urandom_range(0, 3));
            run_txn(s, ciph_op_e'(op), ref_mix(s, op), (op == 2'b00) || (op == 2'b11),
                    "random");
        end
    endtask

    task automatic test_back_to_back();
        state_t s   = rand_state();
        state_t exp = ref_mix(s, 2'b01);
        wait_idle();
        out_ready_i = 1'b0;
        data_i      = s;
        op_i        = CIPH_FWD;
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        data_i     = rand_state();
        repeat (5) step();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (out_valid[j] !== 1'b1 || in_ready[j] !== 1'b0 || dout[j] !== exp) begin
                    errors++;
                    $display("FAIL stall inst%0d got v%b rdy%b d%h required v1 rdy0 d%h",
                             j, out_valid[j], in_ready[j], dout[j], exp);
                end
            end
            step();
        end
        out_ready_i = 1'b1;
        step();
        check_idle("stall_release");
        data_i     = rand_state();
        op_i       = CIPH_INV;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (busy[j] !== 1'b1) begin
                errors++;
                $display("FAIL next_accept inst%0d busy got %b required 1", j, busy[j]);
            end
        end
        repeat (6) step();
    endtask

    task automatic test_reset_mid();
        wait_idle();
        out_ready_i = 1'b1;
        data_i      = rand_state();
        op_i        = CIPH_FWD;
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        step();
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre busy got %b required 1", busy[0]);
        end
        rst_ni = 1'b0;
        #1;
        check_zero_outputs("reset_mid");
        #3;
        rst_ni = 1'b1;
        step();
        check_idle("reset_mid_release");
        check_no_output("reset_mid_after", 6);
    endtask

    task automatic test_clear();
        wait_idle();
        out_ready_i = 1'b1;
        data_i      = rand_state();
        op_i        = CIPH_FWD;
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_idle("clear_mid");
        check_no_output("clear_mid_after", 6);
        // Clear together with an input handshake discards the input
        wait_idle();
        data_i     = rand_state();
        in_valid_i = 1'b1;
        clear_i    = 1'b1;
        step();
        in_valid_i = 1'b0;
        clear_i    = 1'b0;
        check_idle("clear_vs_handshake");
    endtask

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        op_i        = CIPH_FWD;
        data_i      = '0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_mix_columns_seq.md
AES_MIX_COLUMNS_SEQ -- requirements
Module: aes_mix_columns_seq

Interface
REQ-001 SHALL provide parameter: ColsPerCycle, default 1, number of columns transformed per cycle; legal values 1, 2, 4.
REQ-002 SHALL provide port: clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL provide port: rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port: clear_i  input  1  synchronous abort, returns FSM to IDLE.
REQ-005 SHALL provide port: op_i  input  aes_pkg::ciph_op_e  direction, CIPH_FWD or CIPH_INV.
REQ-006 SHALL provide port: in_valid_i  input  1  input state valid.
REQ-007 SHALL provide port: in_ready_o  output  1  block accepts input.
REQ-008 SHALL provide port: data_i  input  [3:0][3:0][7:0]  input state, indexed [row][col].
REQ-009 SHALL provide port: out_valid_o  output  1  result valid.
REQ-010 SHALL provide port: out_ready_i  input  1  consumer accepts result.
REQ-011 SHALL provide port: data_o  output  [3:0][3:0][7:0]  result state, indexed [row][col].
REQ-012 SHALL provide port: busy_o  output  1  high in BUSY or DONE.
REQ-013 SHALL provide port: err_o  output  1  captured op was neither CIPH_FWD nor CIPH_INV; valid with out_valid_o.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL assert in_ready_o only in IDLE; handshake = in_valid_i && in_ready_o.
REQ-016 SHALL, on input handshake, register data_i and op_i, clear column counter, enter BUSY; op_i and data_i are ignored at all other times.
REQ-017 SHALL, in BUSY, each cycle transform ColsPerCycle columns starting at counter c, using ColsPerCycle instances of aes_mix_single_column; column c = {s[3][c], s[2][c], s[1][c], s[0][c]} with element index = row.
REQ-018 SHALL write each transformed column into the result register at the same column position; untransformed columns hold.
REQ-019 SHALL use a 2-bit column counter incrementing by ColsPerCycle, wrapping to 0 after the last column; the wrap cycle transitions BUSY -> DONE.
REQ-020 SHALL assert out_valid_o in DONE only; latency from input handshake to out_valid_o = 4/ColsPerCycle cycles (handshake at edge N -> out_valid_o high after edge N+4/ColsPerCycle).
REQ-021 SHALL hold data_o and err_o stable while out_valid_o && !out_ready_i.
REQ-022 SHALL return DONE -> IDLE on out_valid_o && out_ready_i; in_ready_o is high the following cycle (no same-cycle in/out overlap).
REQ-023 SHALL, for captured op not CIPH_FWD/CIPH_INV, produce data_o = all zero and err_o = 1 at DONE, same latency.
REQ-024 SHALL drive data_o = 0 whenever out_valid_o = 0.
REQ-025 SHALL, on clear_i, go to IDLE next edge from any state, zero result register, counter, err_o; clear_i dominates a simultaneous input or output handshake (handshake discarded).

Reset
REQ-026 SHALL, while rst_ni = 0, force FSM = IDLE, counter = 0, result/captured registers = 0, out_valid_o = 0, busy_o = 0, err_o = 0, data_o = 0; in_ready_o = 1 after reset release.
REQ-027 SHALL abort any in-flight transform on reset assertion mid-operation; no result emitted after release.

Verification
REQ-028 SHALL cover: CIPH_FWD, every column = (db,13,53,45) rows 0..3 -> every column = (8e,4d,a1,bc), out_valid_o 4 cycles after handshake (ColsPerCycle=1).
REQ-029 SHALL cover: CIPH_INV, every column = (8e,4d,a1,bc) -> every column = (db,13,53,45); repeat with ColsPerCycle=2 (latency 2) and 4 (latency 1).
REQ-030 SHALL cover: mixed state, columns (01,01,01,01),(c6,c6,c6,c6),(db,13,53,45),(f2,0a,22,5c) CIPH_FWD -> (01,01,01,01),(c6,c6,c6,c6),(8e,4d,a1,bc),(9f,dc,58,9d).
REQ-031 SHALL cover: out_ready_i held low 10 cycles in DONE -> data_o stable, in_ready_o low; then ready high -> IDLE, next input accepted one cycle later.
REQ-032 SHALL cover: rst_ni pulsed low in BUSY after 2 columns -> all outputs 0 immediately, in_ready_o = 1 after release, no out_valid_o; clear_i same scenario -> IDLE next edge.
REQ-033 SHALL cover: op_i = invalid encoding -> data_o = 0, err_o = 1, out_valid_o at normal latency.
